ado_detector_param: RTL
=======================

# ado_detector_param

Parametrised amplitude-difference (ADO) spike detector. It is the next generation of the single-channel ADO block in the neural front-end and sits between the sample acquisition stage and the spike event encoder. For each valid sample it computes |x[n] − x[n−DELAY]| and compares it against a threshold. The threshold is either supplied externally or learned from a training window. A sample-counted refractory period follows each spike.

## Interface
Parameters:
- DATA_W, 16: sample width, signed two's complement.
- DELAY, 3: sample lag used for the difference; must be ≥1.
- TRAIN_LOG2, 8: training window length is 2^TRAIN_LOG2 samples.
- K_SHIFT, 2: learned threshold = mean ADO << K_SHIFT.
- REFRACT, 16: number of accepted samples suppressed after a spike; 0 disables suppression.
- DEFAULT_THR, 500: threshold after reset, before training completes.

Ports (clock and reset):
- clk, in, 1: single clock; all logic is on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.

Ports (data and control):
- sample_valid, in, 1: data_in is accepted on this cycle.
- data_in, in, DATA_W: signed sample.
- thr_mode, in, 1: 0 selects external threshold_in; 1 selects the learned threshold.
- threshold_in, in, DATA_W: unsigned external threshold.
- train_start, in, 1: single-cycle request to relearn the threshold.

Ports (outputs):
- out_valid, out, 1: one-cycle pulse per decision.
- spike_detected, out, 1: decision; meaningful only when out_valid=1.
- ado_out, out, DATA_W: unsigned ADO value paired with out_valid.
- threshold_out, out, DATA_W: active threshold.
- training, out, 1: high while in FILL or TRAIN.

## Operation
- Delay line of DELAY+1 samples. It shifts only on sample_valid.
- ADO is unsigned DATA_W bits: diff = x[n] − x[n−DELAY] computed at DATA_W+1 bits, then the absolute value. It never overflows; the maximum is 2^DATA_W − 1.
- Spike condition: ado > threshold, strict. Equality is no spike.

State machine:
- FILL: counts DELAY accepted samples, then goes to TRAIN if thr_mode=1, else DETECT.
- TRAIN: accumulates 2^TRAIN_LOG2 ADO values in a DATA_W+TRAIN_LOG2-bit accumulator. On the last one it sets learned = (acc >> TRAIN_LOG2) << K_SHIFT, saturated to 2^DATA_W − 1, then goes to DETECT.
- DETECT: on a spike, goes to REFRACT with the counter set to REFRACT. If REFRACT=0, it stays in DETECT.
- REFRACT: each accepted sample produces out_valid with spike_detected=0 and decrements the counter. At 0 it returns to DETECT.

Mode and threshold handling:
- thr_mode is sampled on FILL exit and on train_start. Changing it at other times has no effect until then.
- With thr_mode=0, threshold_out follows threshold_in on every decision.

train_start:
- In DETECT or REFRACT: the accumulator and count are cleared, the state goes to TRAIN (or DETECT if thr_mode=0), the refractory counter is cleared, and the delay line is kept.
- ADO results produced in the train_start cycle are discarded.
- In FILL or TRAIN: train_start restarts that phase's counting.

No decisions are output in FILL or TRAIN: out_valid=0 and spike_detected=0.

Reset:
- Clears the delay line, counters and accumulator.
- State becomes FILL.
- threshold_out=DEFAULT_THR; all other outputs are 0.
- A mid-operation reset discards any training or refractory period in progress at the next edge.

## Timing
- Two-stage pipeline:
  - Sample accepted at edge t.
  - ADO registered at t+1.
  - Decision, out_valid and ado_out at t+2.
- Accepting back-to-back samples gives one decision per cycle.
- sample_valid gaps stall nothing. The pipeline drains, and out_valid pulses once per accepted sample.
- The learned threshold is in effect for the first decision whose ADO stage completes after the TRAIN exit edge.
- out_valid is a single-cycle pulse; spike_detected is held until the next out_valid.

## Structure
- Package ado_pkg holds:
  - the state enum (FILL, TRAIN, DETECT, REFRACT);
  - the DEFAULT_THR constant;
  - a saturate helper.
- Sub-module ado_absdiff: parametrised delay line plus registered |x[n] − x[n−DELAY]|, with a valid pass-through. The top level holds the FSM, accumulator, threshold and refractory logic.

## Test plan
Unless noted, parameters are DATA_W=16, DELAY=3, TRAIN_LOG2=4, K_SHIFT=2, REFRACT=4.

1. thr_mode=0, threshold_in=500, samples 0,0,0,600,0,0,0,0,0 continuous. Required response:
   - spike_detected=1 and ado_out=600 two cycles after 600 is accepted;
   - the next 4 decisions are 0.
2. thr_mode=0, threshold_in=500, a step producing ado=500 -> out_valid=1, spike_detected=0. A step producing ado=501 -> spike_detected=1.
3. thr_mode=1, a ramp of step 10 for 19 samples, giving ado=30 for 16 training values. Required response:
   - threshold_out=120 after TRAIN;
   - ado=120 gives no spike;
   - ado=121 gives a spike.
4. x[n−3]=−32768, x[n]=32767 -> ado_out=65535, spike_detected=1, no wrap.
5. thr_mode=1, training samples alternating +10000/−10000, giving ado=20000. Required response:
   - the learned value 80000 saturates to 65535;
   - no spike is ever reported.
6. Two cases, both exercised with random sample_valid gaps:
   - rst_n low for one cycle mid-TRAIN -> threshold_out=500, training=1, out_valid stays 0 until FILL and TRAIN complete again;
   - train_start during REFRACT -> no further out_valid until a new training window of 16 samples completes.

Source files
------------

// File: rtl/ado_pkg.sv
// Shared types and helpers for the amplitude-difference spike detector.
package ado_pkg;

  typedef enum logic [1:0] {
    StFill,
    StTrain,
    StDetect,
    StRefract
  } ado_state_e;

  localparam int unsigned DefaultThr = 500;

  // Clamp an unsigned value to the largest number representable in 'width' bits.
  function automatic logic [63:0] saturate(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    if (width >= 64) begin
      max_val = '1;
    end else begin
      max_val = (64'd1 << width) - 64'd1;
    end
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/ado_detector_param_absdiff.sv
// Sample delay line plus registered |x[n] - x[n-DELAY]| with valid pass-through.
module ado_absdiff #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DELAY  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] ado_o
);

  localparam int Depth = int'(DELAY) + 1;

  logic [DATA_W-1:0] line_q [Depth];
  logic              smp_valid_q;
  logic              ado_valid_q;
  logic [DATA_W-1:0] ado_q;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] ado_d;

  // One extra bit keeps the signed difference exact; its magnitude fits DATA_W bits.
  always_comb begin
    diff  = {line_q[0][DATA_W-1], line_q[0]} -
            {line_q[Depth-1][DATA_W-1], line_q[Depth-1]};
    ado_d = diff[DATA_W] ? DATA_W'(-diff) : diff[DATA_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        line_q[i] <= '0;
      end
      smp_valid_q <= 1'b0;
      ado_valid_q <= 1'b0;
      ado_q       <= '0;
    end else begin
      smp_valid_q <= valid_i;
      if (valid_i) begin
        line_q[0] <= data_i;
        for (int i = 1; i < Depth; i++) begin
          line_q[i] <= line_q[i-1];
        end
      end
      ado_valid_q <= smp_valid_q;
      if (smp_valid_q) begin
        ado_q <= ado_d;
      end
    end
  end

  assign valid_o = ado_valid_q;
  assign ado_o   = ado_q;

endmodule

// File: rtl/ado_detector_param.sv
// ADO spike detector: fill/train/detect/refractory control around the abs-diff pipeline.
module ado_detector_param import ado_pkg::*; #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DELAY       = 3,
  parameter int unsigned TRAIN_LOG2  = 8,
  parameter int unsigned K_SHIFT     = 2,
  parameter int unsigned REFRACT     = 16,
  parameter int unsigned DEFAULT_THR = DefaultThr
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              thr_mode,
  input  logic [DATA_W-1:0] threshold_in,
  input  logic              train_start,
  output logic              out_valid,
  output logic              spike_detected,
  output logic [DATA_W-1:0] ado_out,
  output logic [DATA_W-1:0] threshold_out,
  output logic              training
);

  localparam int unsigned AccW  = DATA_W + TRAIN_LOG2;
  localparam int unsigned FillW = $clog2(DELAY + 1);
  localparam int unsigned CntW  = (FillW > TRAIN_LOG2 + 1) ? FillW : TRAIN_LOG2 + 1;
  localparam int unsigned RefW  = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [CntW-1:0] FillLast  = CntW'(DELAY - 1);
  localparam logic [CntW-1:0] TrainLast = CntW'((2 ** TRAIN_LOG2) - 1);

  logic              ado_valid;
  logic [DATA_W-1:0] ado;

  ado_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d, acc_sum;
  logic [RefW-1:0]   ref_q, ref_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] thr_q, thr_d, thr_cmp;
  logic              out_valid_q, out_valid_d;
  logic              spike_q, spike_d;
  logic [DATA_W-1:0] ado_out_q, ado_out_d;
  logic              is_spike;

  ado_absdiff #(
    .DATA_W(DATA_W),
    .DELAY (DELAY)
  ) u_absdiff (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(sample_valid),
    .data_i (data_in),
    .valid_o(ado_valid),
    .ado_o  (ado)
  );

  assign thr_cmp  = mode_q ? thr_q : threshold_in;
  assign is_spike = ado > thr_cmp;
  assign acc_sum  = acc_q + AccW'(ado);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ref_d       = ref_q;
    mode_d      = mode_q;
    thr_d       = thr_q;
    out_valid_d = 1'b0;
    spike_d     = spike_q;
    ado_out_d   = ado_out_q;

    if (train_start) begin
      // The ADO arriving in this cycle is dropped; the delay line is untouched.
      mode_d  = thr_mode;
      cnt_d   = '0;
      acc_d   = '0;
      ref_d   = '0;
      spike_d = 1'b0;
      unique case (state_q)
        StFill:  state_d = StFill;
        StTrain: state_d = StTrain;
        default: state_d = thr_mode ? StTrain : StDetect;
      endcase
    end else if (ado_valid) begin
      unique case (state_q)
        StFill: begin
          if (cnt_q == FillLast) begin
            cnt_d   = '0;
            acc_d   = '0;
            mode_d  = thr_mode;
            state_d = thr_mode ? StTrain : StDetect;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StTrain: begin
          if (cnt_q == TrainLast) begin
            thr_d   = DATA_W'(saturate(64'(acc_sum >> TRAIN_LOG2) << K_SHIFT, DATA_W));
            cnt_d   = '0;
            acc_d   = '0;
            state_d = StDetect;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDetect: begin
          out_valid_d = 1'b1;
          spike_d     = is_spike;
          ado_out_d   = ado;
          if (!mode_q) begin
            thr_d = threshold_in;
          end
          if (is_spike && (REFRACT > 0)) begin
            ref_d   = RefW'(REFRACT);
            state_d = StRefract;
          end
        end
        StRefract: begin
          out_valid_d = 1'b1;
          spike_d     = 1'b0;
          ado_out_d   = ado;
          if (!mode_q) begin
            thr_d = threshold_in;
          end
          if (ref_q <= RefW'(1)) begin
            ref_d   = '0;
            state_d = StDetect;
          end else begin
            ref_d = ref_q - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      acc_q       <= '0;
      ref_q       <= '0;
      mode_q      <= 1'b0;
      thr_q       <= DATA_W'(DEFAULT_THR);
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
      ado_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ref_q       <= ref_d;
      mode_q      <= mode_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      spike_q     <= spike_d;
      ado_out_q   <= ado_out_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign spike_detected = spike_q;
  assign ado_out        = ado_out_q;
  assign threshold_out  = thr_q;
  assign training       = (state_q == StFill) || (state_q == StTrain);

endmodule
